// File: rtl/cs5343_i2s_rx_if.sv
// Stereo sample stream from the CS5343 capture engine toward dafx_core.
// The overrun flag and its clear travel with the stream they describe.
interface cs5343_i2s_rx_if #(
    parameter int SAMPLE_WIDTH_P = 24
) ();
    logic [SAMPLE_WIDTH_P-1:0] rx_left;
    logic [SAMPLE_WIDTH_P-1:0] rx_right;
    logic                      rx_valid;
    logic                      rx_ready;
    logic                      rx_overrun;
    logic                      rx_overrun_clr;

    modport master (
        output rx_left,
        output rx_right,
        output rx_valid,
        output rx_overrun,
        input  rx_ready,
        input  rx_overrun_clr
    );

    modport slave (
        input  rx_left,
        input  rx_right,
        input  rx_valid,
        input  rx_overrun,
        output rx_ready,
        output rx_overrun_clr
    );
endinterface

// File: rtl/cs5343_i2s_rx.sv
// I2S master receiver for the CS5343 ADC: one free-running frame counter drives
// SCLK/LRCK and the capture strobes, and each finished frame is presented as one stereo pair.
module cs5343_i2s_rx #(
    parameter int SAMPLE_WIDTH_P = 24,
    parameter int SLOT_WIDTH_P   = 32,
    parameter int SCLK_DIV_P     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_en,
    output logic               cs_rx_sclk,
    output logic               cs_rx_lrck,
    input  logic               cs_rx_sdin,
    cs5343_i2s_rx_if.master    rx_bus
);
    localparam int CNT_W  = $clog2(SCLK_DIV_P * 2 * SLOT_WIDTH_P);
    localparam int DIV_W  = $clog2(SCLK_DIV_P);
    localparam int SLOT_W = $clog2(SLOT_WIDTH_P);

    localparam logic [DIV_W-1:0]  STROBE_PH = DIV_W'(SCLK_DIV_P / 2);
    localparam logic [SLOT_W-1:0] FIRST_K   = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] LAST_K    = SLOT_W'(SAMPLE_WIDTH_P);

    logic [CNT_W-1:0]          r_cnt;
    logic [SAMPLE_WIDTH_P-1:0] r_shift_l;
    logic [SAMPLE_WIDTH_P-1:0] r_shift_r;
    logic [SAMPLE_WIDTH_P-1:0] r_left;
    logic [SAMPLE_WIDTH_P-1:0] r_right;
    logic                      r_valid;
    logic                      r_overrun;

    logic [DIV_W-1:0]          w_phase;
    logic [SLOT_W-1:0]         w_k;
    logic                      w_right_slot;
    logic                      w_strobe;
    logic                      w_data_bit;
    logic                      w_complete;
    logic                      w_xfer;
    logic                      w_drop;

    assign w_phase      = r_cnt[DIV_W-1:0];
    assign w_k          = r_cnt[DIV_W +: SLOT_W];
    assign w_right_slot = r_cnt[CNT_W-1];
    assign w_strobe     = rx_en && (w_phase == STROBE_PH);
    assign w_data_bit   = (w_k >= FIRST_K) && (w_k <= LAST_K);
    assign w_complete   = w_strobe && w_right_slot && (w_k == LAST_K);
    assign w_xfer       = r_valid && rx_bus.rx_ready;
    assign w_drop       = w_complete && r_valid && !rx_bus.rx_ready;

    // Frame counter; held at zero while idle so every enable starts on a left slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!rx_en) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Deserialisers, MSB first; cleared while idle to drop any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_l <= '0;
            r_shift_r <= '0;
        end else if (!rx_en) begin
            r_shift_l <= '0;
            r_shift_r <= '0;
        end else if (w_strobe && w_data_bit) begin
            if (w_right_slot) begin
                r_shift_r <= {r_shift_r[SAMPLE_WIDTH_P-2:0], cs_rx_sdin};
            end else begin
                r_shift_l <= {r_shift_l[SAMPLE_WIDTH_P-2:0], cs_rx_sdin};
            end
        end else begin
            r_shift_l <= r_shift_l;
            r_shift_r <= r_shift_r;
        end
    end

    // Output pair and handshake; the right LSB is merged straight from the pin on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_left    <= '0;
            r_right   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_complete && !w_drop) begin
                r_left  <= r_shift_l;
                r_right <= {r_shift_r[SAMPLE_WIDTH_P-2:0], cs_rx_sdin};
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (rx_bus.rx_overrun_clr) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign cs_rx_sclk        = r_cnt[DIV_W-1];
    assign cs_rx_lrck        = r_cnt[CNT_W-1];
    assign rx_bus.rx_left    = r_left;
    assign rx_bus.rx_right   = r_right;
    assign rx_bus.rx_valid   = r_valid;
    assign rx_bus.rx_overrun = r_overrun;
endmodule

// File: tb/tb_cs5343_i2s_rx.sv
// Bench for cs5343_i2s_rx: an I2S ADC model clocked by the DUT's own SCLK/LRCK and a
// frame-arithmetic reference of the stream outputs, compared every cycle plus directed checks.
module tb_cs5343_i2s_rx;
    localparam int SW = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic rx_en = 1'b0;
    logic sdin  = 1'b0;
    logic sclk;
    logic lrck;

    cs5343_i2s_rx_if #(.SAMPLE_WIDTH_P(SW)) bus ();

    cs5343_i2s_rx #(
        .SAMPLE_WIDTH_P(SW),
        .SLOT_WIDTH_P  (32),
        .SCLK_DIV_P    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_en     (rx_en),
        .cs_rx_sclk(sclk),
        .cs_rx_lrck(lrck),
        .cs_rx_sdin(sdin),
        .rx_bus    (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state: m_t is the index of the current enabled cycle
    int          m_t     = 0;
    logic        m_valid = 1'b0;
    logic        m_ovr   = 1'b0;
    logic [SW-1:0] m_left  = '0;
    logic [SW-1:0] m_right = '0;

    // ADC model state
    logic [SW-1:0] cur_l = '0;
    logic [SW-1:0] cur_r = '0;
    logic fixed_mode = 1'b0;
    logic need_new   = 1'b1;
    logic side       = 1'b0;
    logic prev_s     = 1'b0;
    logic prev_lr    = 1'b0;
    int   pos        = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic pick_pair();
        if (fixed_mode) begin
            cur_l = 24'h7FFFFF;
            cur_r = 24'h800001;
        end else begin
            cur_l = SW'($urandom);
            cur_r = SW'($urandom);
        end
    endtask

    // ADC: new pair at each left-slot start, bits change on SCLK falling edges, MSB one bit after LRCK edge
    initial forever begin
        @(posedge clk);
        #2;
        if (!rst_n || !rx_en) begin
            need_new = 1'b1;
            pos = 0; side = 1'b0; prev_s = 1'b0; prev_lr = 1'b0;
            sdin = 1'($urandom_range(0, 1));
        end else begin
            if (need_new) begin
                pick_pair();
                need_new = 1'b0; pos = 0; side = 1'b0;
            end else if (prev_s && !sclk) begin
                if (lrck != prev_lr) begin
                    pos = 0;
                    side = lrck;
                    if (!lrck) pick_pair();
                end else begin
                    pos++;
                end
            end
            prev_s  = sclk;
            prev_lr = lrck;
            if (pos >= 1 && pos <= SW) sdin = side ? cur_r[SW-pos] : cur_l[SW-pos];
            else sdin = 1'($urandom_range(0, 1));
        end
    end

    // Reference: a pair completes at frame cycle 226 and is visible from cycle 227
    initial forever begin
        logic complete, drop, xfer;
        @(posedge clk);
        if (!rst_n) begin
            m_t = 0; m_valid = 1'b0; m_ovr = 1'b0; m_left = '0; m_right = '0;
        end else begin
            complete = rx_en && ((m_t % 256) == 226);
            xfer     = m_valid && bus.rx_ready;
            drop     = complete && m_valid && !bus.rx_ready;
            if (complete && !drop) begin
                m_left = cur_l; m_right = cur_r; m_valid = 1'b1;
            end else if (xfer) begin
                m_valid = 1'b0;
            end
            if (drop) m_ovr = 1'b1;
            else if (bus.rx_overrun_clr) m_ovr = 1'b0;
            m_t = rx_en ? m_t + 1 : 0;
        end
    end

    // Per-cycle comparison away from the active edge
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("valid", 32'(bus.rx_valid), 32'(m_valid));
            chk("left", 32'(bus.rx_left), 32'(m_left));
            chk("right", 32'(bus.rx_right), 32'(m_right));
            chk("overrun", 32'(bus.rx_overrun), 32'(m_ovr));
            chk("sclk", 32'(sclk), 32'((m_t % 4) >= 2));
            chk("lrck", 32'(lrck), 32'((m_t % 256) >= 128));
        end else begin
            chk("rst_valid", 32'(bus.rx_valid), 32'd0);
            chk("rst_left", 32'(bus.rx_left), 32'd0);
            chk("rst_sclk", 32'(sclk), 32'd0);
        end
    end

    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (((m_t % 256) != ph) && (n < 600));
        chk("wait_phase", 32'(m_t % 256), 32'(ph));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.rx_valid), 32'd0);
        chk({tag, "_left"}, 32'(bus.rx_left), 32'd0);
        chk({tag, "_right"}, 32'(bus.rx_right), 32'd0);
        chk({tag, "_ovr"}, 32'(bus.rx_overrun), 32'd0);
        chk({tag, "_sclk"}, 32'(sclk), 32'd0);
        chk({tag, "_lrck"}, 32'(lrck), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1);
    end

    initial begin
        int n, sclk_hi, sclk_rise, lrck_lo_first, lrck_hi, nxfer, mode, nval;
        logic ps;
        logic [SW-1:0] sv_l, sv_r, nv_l, nv_r;
        bus.rx_ready = 1'b0;
        bus.rx_overrun_clr = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");

        // reset in the middle of a frame while a pair is held
        rst_n = 1'b1; rx_en = 1'b1;
        wait_phase(228);
        chk("held_before_rst", 32'(bus.rx_valid), 32'd1);
        wait_phase(100);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; bus.rx_ready = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.rx_valid && n < 400);
        chk("first_valid_lat", 32'(n), 32'd227);

        // fixed pattern and clock shape over one aligned frame
        fixed_mode = 1'b1;
        wait_phase(0);
        wait_phase(0);
        sclk_hi = 0; sclk_rise = 0; lrck_lo_first = 0; lrck_hi = 0; nxfer = 0; ps = sclk;
        for (int i = 0; i < 256; i++) begin
            if (sclk) sclk_hi++;
            if (sclk && !ps) sclk_rise++;
            if (lrck) lrck_hi++;
            if (!lrck && i < 128) lrck_lo_first++;
            if (bus.rx_valid && bus.rx_ready) nxfer++;
            if (i == 227) begin
                chk("fix_left", 32'(bus.rx_left), 32'h007FFFFF);
                chk("fix_right", 32'(bus.rx_right), 32'h00800001);
            end
            ps = sclk;
            @(posedge clk);
            #1;
        end
        chk("sclk_high_cycles", 32'(sclk_hi), 32'd128);
        chk("sclk_rises", 32'(sclk_rise), 32'd64);
        chk("lrck_low_first", 32'(lrck_lo_first), 32'd128);
        chk("lrck_high_cycles", 32'(lrck_hi), 32'd128);
        chk("pairs_per_frame", 32'(nxfer), 32'd1);
        fixed_mode = 1'b0;

        // random data with per-frame ready behaviour and stray overrun clears
        for (int f = 0; f < 8; f++) begin
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 256; i++) begin
                @(posedge clk);
                #1;
                case (mode)
                    0:       bus.rx_ready = 1'b0;
                    1:       bus.rx_ready = ($urandom_range(0, 7) == 0);
                    default: bus.rx_ready = 1'b1;
                endcase
                bus.rx_overrun_clr = ($urandom_range(0, 63) == 0);
            end
        end
        bus.rx_ready = 1'b1; bus.rx_overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_overrun_clr = 1'b0;

        // consumer stalls for three frames
        wait_phase(0);
        bus.rx_ready = 1'b0;
        wait_phase(10);
        sv_l = cur_l; sv_r = cur_r;
        wait_phase(228);
        chk("stall_f1_valid", 32'(bus.rx_valid), 32'd1);
        chk("stall_f1_ovr", 32'(bus.rx_overrun), 32'd0);
        wait_phase(228);
        chk("stall_f2_ovr", 32'(bus.rx_overrun), 32'd1);
        wait_phase(226);
        bus.rx_overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_overrun_clr = 1'b0;
        chk("ovr_set_wins", 32'(bus.rx_overrun), 32'd1);
        wait_phase(228);
        chk("stall_hold_left", 32'(bus.rx_left), 32'(sv_l));
        chk("stall_hold_right", 32'(bus.rx_right), 32'(sv_r));
        chk("stall_f3_valid", 32'(bus.rx_valid), 32'd1);
        bus.rx_overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_overrun_clr = 1'b0;
        chk("ovr_cleared", 32'(bus.rx_overrun), 32'd0);
        bus.rx_ready = 1'b1;

        // disable mid-frame, then a clean frame after re-enable
        wait_phase(150);
        rx_en = 1'b0;
        @(posedge clk);
        #1;
        chk("dis_sclk", 32'(sclk), 32'd0);
        chk("dis_lrck", 32'(lrck), 32'd0);
        nval = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rx_valid) nval++;
            @(posedge clk);
            #1;
        end
        chk("dis_no_valid", 32'(nval), 32'd0);
        rx_en = 1'b1;
        wait_phase(10);
        sv_l = cur_l; sv_r = cur_r;
        wait_phase(227);
        chk("reen_valid", 32'(bus.rx_valid), 32'd1);
        chk("reen_left", 32'(bus.rx_left), 32'(sv_l));
        chk("reen_right", 32'(bus.rx_right), 32'(sv_r));

        // ready rises exactly in the pair-complete cycle
        wait_phase(10);
        bus.rx_ready = 1'b0;
        sv_l = cur_l; sv_r = cur_r;
        wait_phase(228);
        chk("rc_held", 32'(bus.rx_valid), 32'd1);
        wait_phase(10);
        nv_l = cur_l; nv_r = cur_r;
        wait_phase(226);
        bus.rx_ready = 1'b1;
        chk("rc_old_left", 32'(bus.rx_left), 32'(sv_l));
        chk("rc_old_right", 32'(bus.rx_right), 32'(sv_r));
        @(posedge clk);
        #1;
        chk("rc_valid_stays", 32'(bus.rx_valid), 32'd1);
        chk("rc_new_left", 32'(bus.rx_left), 32'(nv_l));
        chk("rc_new_right", 32'(bus.rx_right), 32'(nv_r));
        chk("rc_no_ovr", 32'(bus.rx_overrun), 32'd0);
        @(posedge clk);
        #1;
        chk("rc_valid_drop", 32'(bus.rx_valid), 32'd0);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
